piso_shift_tx: RTL

- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock on sout, framed by sout_valid.
- Serves as the sending end for a D-flip-flop-based serial capture path: a downstream DFF or shift register samples sout on each posedge clk while sout_valid=1.
- Serves as a reusable stimulus source for flip-flop and register benches.

---
 rtl/piso_pkg.sv | 23 ++
 rtl/piso_shift_tx_if.sv | 38 +++
 rtl/piso_shreg.sv | 49 ++++
 rtl/piso_shift_tx.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piso_pkg
// Purpose  : Shared types and helpers for the piso_shift_tx transmitter:
//            FSM state encoding and the bit-counter width function.
// Revision : 1.0 - initial release
// ============================================================================
package piso_pkg;

  // Transmitter FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Counter must hold 0..width (it steps to width on the last data bit)
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_shift_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_tx_if
// Purpose  : Load handshake and serial output bundle of piso_shift_tx.
//            master = word source / serial sink, slave = transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface piso_shift_tx_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  done
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output sout,
    output sout_valid,
    output done
  );

endinterface : piso_shift_tx_if
`default_nettype wire

// File: rtl/piso_shreg.sv
`default_nettype none
// ============================================================================
// Module   : piso_shreg
// Purpose  : WIDTH-bit loadable shift register. Shifts toward the head end
//            (MSB or LSB per MSB_FIRST) and inserts 'fill' at the tail, so a
//            fully shifted-out register reads back as the fill bits.
// Revision : 1.0 - initial release
// ============================================================================
module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             shift_en,
  input  wire logic             fill,
  input  wire logic [WIDTH-1:0] din,
  output logic                  head_bit
);

  import piso_pkg::*;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_shifted;

  generate
    if (MSB_FIRST) begin : g_msb
      assign q_shifted = {q[WIDTH-2:0], fill};
      assign head_bit  = q[WIDTH-1];
    end else begin : g_lsb
      assign q_shifted = {fill, q[WIDTH-1:1]};
      assign head_bit  = q[0];
    end
  endgenerate

  // Storage: load has priority over shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift_en) begin
      q <= q_shifted;
    end
  end

endmodule : piso_shreg
`default_nettype wire

// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_shift_tx
// Purpose  : Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word on
//            a valid/ready handshake and sends it one bit per clock on sout,
//            framed by sout_valid, with a one-cycle done pulse afterwards.
//            Optional macro PISO_TX_PARITY_EN appends an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input wire logic        clk,
  input wire logic        rst,
  piso_shift_tx_if.slave  bus
);

  import piso_pkg::*;

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          valid_q, valid_nxt;
  logic          ready_q, ready_nxt;
  logic          done_q, done_nxt;
  logic          accept;
  logic          final_cycle;
  logic          load;
  logic          shift_en;
  logic          fill;
  logic          head_bit;

  assign accept = ready_q & bus.load_valid;

`ifdef PISO_TX_PARITY_EN
  logic par_q;

  // Parity of the word is frozen at load time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^bus.data_in;
    end
  end

  // Parity enters at the tail on the first shift, so it reaches the head
  // exactly after the last data bit has been presented.
  assign fill        = par_q & (cnt == '0);
  assign final_cycle = (state == PARITY);
`else
  assign fill        = 1'b0;
  assign final_cycle = (state == SHIFT) && (cnt == LAST);
`endif

  // sout is the shift register head flop itself; zero fill guarantees it
  // reads 0 once a frame has been fully shifted out.
  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .fill     (fill),
    .din      (bus.data_in),
    .head_bit (head_bit)
  );

  // Next-state, counter and registered-output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    valid_nxt = 1'b0;
    ready_nxt = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;

    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_nxt  = cnt + CW'(1);
        if (cnt != LAST) begin
          valid_nxt = 1'b1;
`ifdef PISO_TX_PARITY_EN
          ready_nxt = 1'b0;
`else
          ready_nxt = (cnt_nxt == LAST);
`endif
        end else begin
`ifdef PISO_TX_PARITY_EN
          state_nxt = PARITY;
          valid_nxt = 1'b1;
          ready_nxt = 1'b1;
`else
          state_nxt = IDLE;
          ready_nxt = 1'b1;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        shift_en  = 1'b1;
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
`endif
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
    endcase

    // A new word (from IDLE or the final frame cycle) overrides the above
    if (accept) begin
      load      = 1'b1;
      shift_en  = 1'b0;
      state_nxt = SHIFT;
      cnt_nxt   = '0;
      valid_nxt = 1'b1;
      ready_nxt = 1'b0;
    end
  end

  assign done_nxt = final_cycle;

  // State, counter and registered handshake/framing outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      valid_q <= valid_nxt;
      ready_q <= ready_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.sout       = head_bit;
  assign bus.sout_valid = valid_q;
  assign bus.load_ready = ready_q;
  assign bus.done       = done_q;

endmodule : piso_shift_tx
`default_nettype wire
